// File: rtl/playout_buffer.sv
// Receive-side jitter buffer: stores whole 16-byte audio blocks in a ring and
// hands out one signed 8-bit sample per request tick. It primes before playback
// starts and plays silence on underrun.
module playout_buffer #(
  parameter int unsigned DEPTH_BLOCKS = 4,
  parameter int unsigned PRIME_BLOCKS = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              block_valid_in,
  input  logic [15:0][7:0]                  block_in,
  input  logic                              request_in,
  output logic signed [7:0]                 sample_out,
  output logic                              sample_valid_out,
  output logic                              underrun_out,
  output logic                              overflow_out,
  output logic [$clog2(DEPTH_BLOCKS+1)-1:0] level_out,
  output logic                              playing_out
);

  localparam int unsigned CntW = $clog2(DEPTH_BLOCKS + 1);
  localparam int unsigned PtrW = $clog2(DEPTH_BLOCKS);

  typedef enum logic [0:0] {StPrime, StPlay} state_e;

  state_e state_q, state_d;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]      byte_idx_q, byte_idx_d;
  logic [CntW-1:0] count_q, count_d;

  logic [7:0] sample_q, sample_d;
  logic       valid_q, valid_d;
  logic       underrun_q, underrun_d;
  logic       overflow_q, overflow_d;

  // Block storage; contents are deliberately left untouched by reset.
  logic [15:0][7:0] mem_q [DEPTH_BLOCKS];

  logic full;
  logic wr_accept;
  logic slot_free;

  // Next-state logic: write acceptance, sample serving and prime/play control.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_idx_d = byte_idx_q;
    sample_d   = sample_q;
    valid_d    = request_in;
    underrun_d = 1'b0;
    slot_free  = 1'b0;

    // Overflow is judged on the occupancy before any same-cycle slot free.
    full       = (count_q == CntW'(DEPTH_BLOCKS));
    wr_accept  = block_valid_in && !full;
    overflow_d = block_valid_in && full;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end

    unique case (state_q)
      StPrime: begin
        if (request_in) begin
          sample_d = 8'h00;
        end
      end
      StPlay: begin
        if (request_in) begin
          if (count_q != '0) begin
            sample_d = mem_q[rd_ptr_q][byte_idx_q];
            if (byte_idx_q == 4'd15) begin
              byte_idx_d = 4'd0;
              rd_ptr_d   = rd_ptr_q + PtrW'(1);
              slot_free  = 1'b1;
            end else begin
              byte_idx_d = byte_idx_q + 4'd1;
            end
          end else begin
            sample_d   = 8'h00;
            underrun_d = 1'b1;
            byte_idx_d = 4'd0;
            state_d    = StPrime;
          end
        end
      end
    endcase

    count_d = count_q + CntW'(wr_accept) - CntW'(slot_free);

    // A request that coincides with the threshold crossing was already served as silence.
    if (state_q == StPrime && count_d >= CntW'(PRIME_BLOCKS)) begin
      state_d = StPlay;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StPrime;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_idx_q <= '0;
      count_q    <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_idx_q <= byte_idx_d;
      count_q    <= count_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  // Whole-block write into the slot at the write pointer.
  always_ff @(posedge clk_in) begin
    if (!rst_in && wr_accept) begin
      mem_q[wr_ptr_q] <= block_in;
    end
  end

  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign underrun_out     = underrun_q;
  assign overflow_out     = overflow_q;
  assign level_out        = count_q;
  assign playing_out      = (state_q == StPlay);

endmodule
